apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have parameter NSEL, default 2, number of PSEL outputs (slaves).
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum ACCESS-phase wait cycles; only used when APB_CMD_MASTER_TIMEOUT_EN is defined.
REQ-005 SHALL have ports, one per line (one clock; reset asynchronous, active-low):
  PCLK  in  1  clock
  PRESETN  in  1  asynchronous active-low reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_write  in  1  1=write, 0=read
  cmd_sel  in  $clog2(NSEL)  slave index
  cmd_addr  in  ADDR_W  address
  cmd_wdata  in  DATA_W  write data
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  DATA_W  read data (0 for writes)
  resp_err  out  1  PSLVERR or timeout
  resp_timeout  out  1  transfer ended by timeout
  PSEL  out  NSEL  one-hot slave select
  PENABLE, PWRITE  out  1  APB controls
  PADDR  out  ADDR_W  APB address
  PWDATA  out  DATA_W  APB write data
  PRDATA  in  DATA_W  APB read data
  PREADY, PSLVERR  in  1  APB response

Function
REQ-006 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-007 SHALL assert cmd_ready only in IDLE; accept on cmd_valid&cmd_ready; register cmd_* fields at acceptance.
REQ-008 SHALL, in SETUP (cycle after acceptance), drive PSEL[cmd_sel]=1, PENABLE=0, PADDR/PWRITE/PWDATA from registered command.
REQ-009 SHALL unconditionally go SETUP -> ACCESS; ACCESS drives PENABLE=1, PSEL/PADDR/PWRITE/PWDATA unchanged.
REQ-010 SHALL stay in ACCESS while PREADY=0; on PREADY=1 edge, capture PRDATA (reads only) and PSLVERR, go IDLE.
REQ-011 SHALL pulse resp_valid in the cycle after completion with resp_rdata/resp_err/resp_timeout; minimum cmd-accept to resp_valid latency = 3 cycles.
REQ-012 SHALL hold resp_rdata/resp_err/resp_timeout stable until the next completion.
REQ-013 SHALL drive PSEL=0, PENABLE=0 in IDLE; PADDR/PWDATA/PWRITE hold last value.
REQ-014 SHALL allow back-to-back commands: cmd_ready high in the IDLE cycle concurrent with resp_valid; next SETUP follows immediately.
REQ-015 SHALL treat cmd_sel >= NSEL as no select (PSEL=0), completing after ACCESS with resp_err=1, no PREADY wait.

Reset
REQ-016 SHALL, on PRESETN low, asynchronously enter IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, resp_*=0, cmd_ready=0 while reset asserted, 1 on first cycle after release.
REQ-017 SHALL abort any in-flight transfer on reset with no resp_valid.

Configuration
REQ-018 SHALL, with APB_CMD_MASTER_TIMEOUT_EN defined, count ACCESS cycles with PREADY=0; at TIMEOUT, drop to IDLE with resp_err=1, resp_timeout=1, resp_rdata=0.
REQ-019 SHALL, without APB_CMD_MASTER_TIMEOUT_EN, wait indefinitely for PREADY and tie resp_timeout to 0.

Structure
REQ-020 SHALL place FSM state enum and response-flag constants in shared package apb_cmd_master_pkg.
REQ-021 SHALL be a single module; no sub-module.

Verification
REQ-022 Write sel=0 addr=0x04 wdata=0xA5, PREADY=1 -> SETUP then ACCESS, PSEL=2'b01, PWDATA=0xA5, resp_valid at cycle 3, resp_err=0.
REQ-023 Read sel=1 addr=0x10, PRDATA=0x3C, PREADY low 4 cycles -> PENABLE high 5 cycles, resp_rdata=0x3C, resp_valid 7 cycles after accept.
REQ-024 Read with PSLVERR=1 at completion -> resp_err=1, resp_timeout=0.
REQ-025 Two commands with cmd_valid held -> second SETUP in cycle immediately after first resp_valid, no idle gap beyond one IDLE cycle.
REQ-026 With macro, TIMEOUT=8, PREADY=0 forever -> resp_valid after 8 ACCESS cycles, resp_err=1, resp_timeout=1; without macro, PENABLE stays high.
REQ-027 PRESETN low during ACCESS -> PSEL=0, PENABLE=0 immediately, no resp_valid; next command completes normally.

Source files
------------

// File: rtl/apb_cmd_master_pkg.sv
// rtl/apb_cmd_master_pkg.sv - shared FSM state and response-flag definitions for apb_cmd_master
package apb_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic err;
        logic timeout;
    } resp_flags_t;

    localparam resp_flags_t RESP_OK      = '{err: 1'b0, timeout: 1'b0};
    localparam resp_flags_t RESP_SLVERR  = '{err: 1'b1, timeout: 1'b0};
    localparam resp_flags_t RESP_NOSEL   = '{err: 1'b1, timeout: 1'b0};
    localparam resp_flags_t RESP_TIMEOUT = '{err: 1'b1, timeout: 1'b1};

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command-queue to APB master bridge; APB_CMD_MASTER_TIMEOUT_EN adds an ACCESS-phase timeout
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int NSEL    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                     PCLK,
    input  logic                     PRESETN,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [$clog2(NSEL)-1:0]  cmd_sel,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     resp_valid,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_err,
    output logic                     resp_timeout,
    output logic [NSEL-1:0]          PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    state_t            state;
    logic              sel_ok;
    logic              cmd_sel_ok;
    logic [NSEL-1:0]   sel_dec;
    logic              done;
    resp_flags_t       done_flags;
    logic [DATA_W-1:0] done_rdata;

    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NSEL; i++) begin
            if (int'(cmd_sel) == i) sel_dec[i] = 1'b1;
        end
    end

    assign cmd_sel_ok = int'(cmd_sel) < NSEL;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`endif

    // An unselected slave cannot answer, so the transfer ends after one ACCESS cycle.
    always_comb begin
        done       = 1'b0;
        done_flags = RESP_OK;
        done_rdata = '0;
        if (state == ST_ACCESS) begin
            if (!sel_ok) begin
                done       = 1'b1;
                done_flags = RESP_NOSEL;
            end else if (PREADY) begin
                done       = 1'b1;
                done_flags = PSLVERR ? RESP_SLVERR : RESP_OK;
                done_rdata = PWRITE ? '0 : PRDATA;
            end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            else if (tmo_hit) begin
                done       = 1'b1;
                done_flags = RESP_TIMEOUT;
            end
`endif
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b0;
            sel_ok       <= 1'b0;
            PSEL         <= '0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state     <= ST_SETUP;
                        cmd_ready <= 1'b0;
                        sel_ok    <= cmd_sel_ok;
                        PSEL      <= sel_dec;
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (done) begin
                        state        <= ST_IDLE;
                        PSEL         <= '0;
                        PENABLE      <= 1'b0;
                        cmd_ready    <= 1'b1;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= done_rdata;
                        resp_err     <= done_flags.err;
                        resp_timeout <= done_flags.timeout;
                    end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master (honours APB_CMD_MASTER_TIMEOUT_EN)
module tb_apb_cmd_master;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int NSEL    = 3;
    localparam int TIMEOUT = 8;
    localparam int SEL_W   = $clog2(NSEL);
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int MAXW   = 11;
    localparam int RST_AT = 4;
`else
    localparam int MAXW   = 6;
    localparam int RST_AT = 12;
`endif

    logic              PCLK = 1'b0;
    logic              PRESETN = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [SEL_W-1:0]  cmd_sel = '0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              resp_timeout;
    logic [NSEL-1:0]   PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              PREADY = 1'b0;
    logic              PSLVERR = 1'b0;

    apb_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_timeout(resp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial forever #5 PCLK = ~PCLK;

    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              tmo;
        int                acc;
        int                lat;
        int                pen;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                n_chk = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                slv_wait = 0;
    int                slv_cnt = 0;
    int                pen_cnt = 0;
    logic [DATA_W+1:0] last_resp = '0;

    always @(posedge PCLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [NSEL-1:0] exp_psel(input logic [SEL_W-1:0] sel);
        logic [NSEL-1:0] r = '0;
        if (int'(sel) < NSEL) r[sel] = 1'b1;
        return r;
    endfunction

    // Reference: result and timing derived from the transfer rules, not the state machine.
    function automatic exp_t model(input logic [SEL_W-1:0] sel, input logic wr,
                                   input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                   input logic [DATA_W-1:0] prdata, input logic slverr,
                                   input int wt, input int acc);
        exp_t e;
        logic ok = int'(sel) < NSEL;
        e.sel   = sel;
        e.write = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.acc   = acc;
        e.err   = !ok || slverr;
        e.rdata = (ok && !wr) ? prdata : '0;
        e.tmo   = 1'b0;
        e.pen   = ok ? wt + 1 : 1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        if (ok && wt >= TIMEOUT) begin
            e.err   = 1'b1;
            e.tmo   = 1'b1;
            e.rdata = '0;
            e.pen   = TIMEOUT;
        end
`endif
        e.lat = 2 + e.pen;
        return e;
    endfunction

    // Slave: PREADY rises after slv_wait ACCESS cycles.
    always @(negedge PCLK) begin
        if (PRESETN && PENABLE && PSEL != '0) begin
            PREADY = (slv_cnt >= slv_wait);
            slv_cnt++;
        end else begin
            PREADY  = 1'b0;
            slv_cnt = 0;
        end
    end

    always @(negedge PCLK) begin
        if (PRESETN) begin
            if (exp_q.size() > 0 && cyc == exp_q[0].acc + 1) begin
                check("setup_penable", 32'(PENABLE), 32'(0));
                check("setup_psel", 32'(PSEL), 32'(exp_psel(exp_q[0].sel)));
                check("setup_paddr", 32'(PADDR), 32'(exp_q[0].addr));
                check("setup_pwrite", 32'(PWRITE), 32'(exp_q[0].write));
                if (exp_q[0].write) check("setup_pwdata", 32'(PWDATA), 32'(exp_q[0].wdata));
            end
            if (PENABLE) begin
                pen_cnt++;
                if (exp_q.size() > 0) check("access_psel", 32'(PSEL), 32'(exp_psel(exp_q[0].sel)));
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got resp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_rdata", 32'(resp_rdata), 32'(mon_e.rdata));
                    check("resp_err", 32'(resp_err), 32'(mon_e.err));
                    check("resp_timeout", 32'(resp_timeout), 32'(mon_e.tmo));
                    check("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    check("penable_cycles", 32'(pen_cnt), 32'(mon_e.pen));
                    check("idle_psel_penable", 32'({PSEL, PENABLE}), 32'(0));
                end
                pen_cnt   = 0;
                last_resp = {resp_rdata, resp_err, resp_timeout};
            end else begin
                check("resp_hold", 32'({resp_rdata, resp_err, resp_timeout}), 32'(last_resp));
            end
        end
    end

    task automatic issue(input logic [SEL_W-1:0] sel, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] prdata,
                         input logic slverr, input int wt);
        int k = 0;
        cmd_sel   = sel;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 100) begin
            @(negedge PCLK);
            k++;
        end
        if (!cmd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_wait: got cmd_ready=0 for 100 cycles expected 1");
            cmd_valid = 1'b0;
            return;
        end
        slv_wait = wt;
        PRDATA   = prdata;
        PSLVERR  = slverr;
        exp_q.push_back(model(sel, wr, addr, wdata, prdata, slverr, wt, cyc));
        @(negedge PCLK);
    endtask

    task automatic drain();
        int k = 0;
        cmd_valid = 1'b0;
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge PCLK);
            k++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge PCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        @(negedge PCLK);
        check("reset_outputs", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'(0));
        check("reset_resp", 32'({resp_valid, resp_rdata, resp_err, resp_timeout}), 32'(0));
        check("reset_cmd_ready", 32'(cmd_ready), 32'(0));
        PRESETN = 1'b1;
        @(posedge PCLK);
        #1;
        check("ready_after_reset", 32'(cmd_ready), 32'(1));
        @(negedge PCLK);

        issue(0, 1'b1, 5'h04, 8'hA5, 8'h00, 1'b0, 0);
        drain();
        issue(1, 1'b0, 5'h10, 8'h00, 8'h3C, 1'b0, 4);
        drain();
        issue(1, 1'b0, 5'h0B, 8'h00, 8'h77, 1'b1, 2);
        drain();
        issue(0, 1'b1, 5'h01, 8'h11, 8'h00, 1'b0, 0);
        issue(2, 1'b0, 5'h1F, 8'h00, 8'hC3, 1'b0, 1);
        issue(3, 1'b0, 5'h02, 8'h00, 8'h99, 1'b0, 0);
        drain();
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        issue(2, 1'b0, 5'h06, 8'h00, 8'hEE, 1'b0, 50);
        drain();
`endif

        for (int t = 0; t < 40; t++) begin
            issue(SEL_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ADDR_W'($urandom),
                  DATA_W'($urandom), DATA_W'($urandom), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, MAXW)));
            if ($urandom_range(0, 1) == 1) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge PCLK);
            end
        end
        drain();

        issue(1, 1'b0, 5'h07, 8'h00, 8'h55, 1'b0, 30);
        cmd_valid = 1'b0;
        repeat (RST_AT) @(negedge PCLK);
        check("access_before_reset", 32'(PENABLE), 32'(1));
        #2;
        PRESETN = 1'b0;
        #1;
        check("abort_psel_penable", 32'({PSEL, PENABLE}), 32'(0));
        check("abort_resp", 32'({resp_valid, resp_rdata, resp_err, resp_timeout}), 32'(0));
        check("abort_cmd_ready", 32'(cmd_ready), 32'(0));
        exp_q.delete();
        pen_cnt   = 0;
        last_resp = '0;
        slv_wait  = 0;
        repeat (2) @(negedge PCLK);
        PRESETN = 1'b1;
        @(posedge PCLK);
        #1;
        check("ready_after_abort", 32'(cmd_ready), 32'(1));
        @(negedge PCLK);
        issue(2, 1'b0, 5'h15, 8'h00, 8'h6A, 1'b0, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
